// File: rtl/alarm_dismiss_game.sv
`default_nettype none
// ============================================================================
// alarm_dismiss_game : "press the lit button" game that dismisses a ringing alarm
// Rev 1.0
// ============================================================================
module alarm_dismiss_game #(
    parameter int ROUNDS        = 4,
    parameter int TIMEOUT_TICKS = 5,
    parameter int MAX_RETRY     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alarm_active_i,
    input  logic [1:0] rand_val_i,
    input  logic [3:0] btn_i,
    input  logic       tick_i,
    output logic       lfsr_enable_o,
    output logic       lfsr_stop_o,
    output logic [3:0] led_o,
    output logic [3:0] round_cnt_o,
    output logic       miss_o,
    output logic       dismiss_o,
    output logic       busy_o
);

    localparam int c_RETRY_W = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SPIN   = 3'd1,
        S_SAMPLE = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4,
        S_HOLD   = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           target_q, target_d;
    logic [1:0]           prev_q, prev_d;
    logic [c_RETRY_W-1:0] retry_q, retry_d;
    logic [7:0]           tick_q, tick_d;
    logic [3:0]           round_q, round_d;
    logic                 miss_d, dismiss_d;
    logic [3:0]           target_oh;

    assign target_oh   = 4'b0001 << target_q;
    assign round_cnt_o = round_q;

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        prev_d    = prev_q;
        retry_d   = retry_q;
        tick_d    = tick_q;
        round_d   = round_q;
        miss_d    = 1'b0;
        dismiss_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (alarm_active_i) begin
                    round_d = 4'd0;
                    prev_d  = 2'd0;
                    retry_d = '0;
                    state_d = S_SPIN;
                end
            end
            S_SPIN: begin
                if (!alarm_active_i) begin
                    round_d = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (!alarm_active_i) begin
                    round_d = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    target_d = rand_val_i;
                    // Re-spin a repeated target, but only a bounded number of times
                    if ((rand_val_i == prev_q) && (retry_q < c_RETRY_W'(MAX_RETRY))) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_SPIN;
                    end else begin
                        retry_d = '0;
                        tick_d  = 8'd0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!alarm_active_i) begin
                    round_d = 4'd0;
                    state_d = S_IDLE;
                end else if (btn_i == target_oh) begin
                    // A correct press wins over a simultaneous terminal tick
                    prev_d = target_q;
                    if (round_q < 4'(ROUNDS)) begin
                        round_d = round_q + 4'd1;
                    end
                    if ((round_q + 4'd1) >= 4'(ROUNDS)) begin
                        dismiss_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_SPIN;
                    end
                end else if ((btn_i != 4'd0) ||
                             (tick_i && (tick_q == 8'(TIMEOUT_TICKS - 1)))) begin
                    miss_d  = 1'b1;
                    round_d = 4'd0;
                    prev_d  = target_q;
                    state_d = S_SPIN;
                end else if (tick_i) begin
                    tick_d = tick_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!alarm_active_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            target_q      <= 2'd0;
            prev_q        <= 2'd0;
            retry_q       <= '0;
            tick_q        <= 8'd0;
            round_q       <= 4'd0;
            lfsr_enable_o <= 1'b0;
            lfsr_stop_o   <= 1'b1;
            led_o         <= 4'd0;
            miss_o        <= 1'b0;
            dismiss_o     <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            prev_q        <= prev_d;
            retry_q       <= retry_d;
            tick_q        <= tick_d;
            round_q       <= round_d;
            lfsr_enable_o <= (state_d == S_SPIN);
            lfsr_stop_o   <= (state_d == S_IDLE) || (state_d == S_HOLD);
            led_o         <= (state_d == S_WAIT) ? (4'b0001 << target_d) : 4'd0;
            miss_o        <= miss_d;
            dismiss_o     <= dismiss_d;
            busy_o        <= (state_d != S_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alarm_dismiss_game.sv
`default_nettype none
// ============================================================================
// tb_alarm_dismiss_game : randomized round-level checks of the dismissal game
// Rev 1.0
// ============================================================================
module tb_alarm_dismiss_game;

    localparam int ROUNDS        = 4;
    localparam int TIMEOUT_TICKS = 5;
    localparam int MAX_RETRY     = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alarm = 1'b0;
    logic [1:0] rv = 2'd0;
    logic [3:0] btn = 4'd0;
    logic       tick = 1'b0;
    logic       lfsr_enable, lfsr_stop, miss, dismiss, busy;
    logic [3:0] led, round_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int m_round = 0;
    int m_prev  = 0;

    alarm_dismiss_game #(
        .ROUNDS(ROUNDS), .TIMEOUT_TICKS(TIMEOUT_TICKS), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .alarm_active_i(alarm), .rand_val_i(rv),
        .btn_i(btn), .tick_i(tick), .lfsr_enable_o(lfsr_enable),
        .lfsr_stop_o(lfsr_stop), .led_o(led), .round_cnt_o(round_cnt),
        .miss_o(miss), .dismiss_o(dismiss), .busy_o(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_stop"}, lfsr_stop, 1);
        chk({tag, "_en"}, lfsr_enable, 0);
        chk({tag, "_led"}, led, 0);
        chk({tag, "_cnt"}, round_cnt, 0);
        chk({tag, "_miss"}, miss, 0);
        chk({tag, "_dismiss"}, dismiss, 0);
    endtask

    task automatic start_game();
        alarm = 1'b1;
        step();
        m_round = 0;
        m_prev  = 0;
        chk("start_en", lfsr_enable, 1);
        chk("start_busy", busy, 1);
        chk("start_stop", lfsr_stop, 0);
    endtask

    // Called on the SPIN cycle; returns the accepted target once LEDs light.
    task automatic spin(input int fv, output int tgt, output int nretry);
        int v;
        nretry = 0;
        tgt    = 0;
        for (int i = 0; i <= MAX_RETRY; i++) begin
            chk("spin_en", lfsr_enable, 1);
            if (fv >= 0) v = fv;
            else v = ($urandom_range(0, 2) == 0) ? m_prev : int'($urandom_range(0, 3));
            rv = 2'(v);
            step();
            chk("sample_en", lfsr_enable, 0);
            chk("sample_miss", miss, 0);
            chk("sample_led", led, 0);
            step();
            if (v == m_prev && nretry < MAX_RETRY) begin
                nretry++;
            end else begin
                tgt = v;
                chk("led", led, 32'd1 << v);
                chk("wait_en", lfsr_enable, 0);
                break;
            end
        end
    endtask

    // res: 0 = next round spinning, 1 = won, 2 = aborted, 3 = bound expired
    task automatic wait_phase(input int tgt, input int mode, input logic [3:0] wbtn,
                              output int res);
        int ticks = 0;
        logic [3:0] b, oh;
        logic t;
        oh  = 4'b0001 << tgt;
        res = 3;
        for (int cyc = 0; cyc < 200; cyc++) begin
            b = 4'd0;
            t = 1'b0;
            case (mode)
                0: begin
                    int r = $urandom_range(0, 9);
                    t = ($urandom_range(0, 3) == 0) || (cyc > 100);
                    if (r < 3) b = oh;
                    else if (r == 3) b = 4'($urandom_range(1, 15));
                end
                1: if (cyc == 2) b = wbtn;
                2: t = 1'b1;
                3: begin
                    t = 1'b1;
                    if (ticks == TIMEOUT_TICKS - 1) b = oh;
                end
                4: if (cyc == 1) alarm = 1'b0;
                default: b = oh;
            endcase
            btn  = b;
            tick = t;
            step();
            btn  = 4'd0;
            tick = 1'b0;
            if (!alarm) begin
                m_round = 0;
                chk_idle("abort");
                res = 2;
                return;
            end
            if (b == oh) begin
                m_round++;
                m_prev = tgt;
                chk("hit_miss", miss, 0);
                chk("hit_cnt", round_cnt, m_round);
                chk("hit_led", led, 0);
                if (m_round == ROUNDS) begin
                    chk("win_dismiss", dismiss, 1);
                    chk("win_en", lfsr_enable, 0);
                    res = 1;
                end else begin
                    chk("hit_dismiss", dismiss, 0);
                    chk("hit_en", lfsr_enable, 1);
                    res = 0;
                end
                return;
            end
            ticks += int'(t);
            if (b != 4'd0 || ticks == TIMEOUT_TICKS) begin
                m_round = 0;
                m_prev  = tgt;
                chk("miss", miss, 1);
                chk("miss_cnt", round_cnt, 0);
                chk("miss_en", lfsr_enable, 1);
                chk("miss_led", led, 0);
                res = 0;
                return;
            end
            chk("wait_miss", miss, 0);
            chk("wait_led", led, oh);
            chk("wait_cnt", round_cnt, m_round);
        end
        chk("wait_bound", 0, 1);
    endtask

    task automatic finish_game();
        step();
        chk("hold_dismiss", dismiss, 0);
        chk("hold_busy", busy, 1);
        chk("hold_stop", lfsr_stop, 1);
        chk("hold_led", led, 0);
        chk("hold_en", lfsr_enable, 0);
        for (int i = 0; i < 3; i++) begin
            btn  = 4'($urandom_range(0, 15));
            tick = 1'($urandom_range(0, 1));
            step();
            chk("hold_nodismiss", dismiss, 0);
            chk("hold_nomiss", miss, 0);
        end
        btn   = 4'd0;
        tick  = 1'b0;
        alarm = 1'b0;
        step();
        chk("release_busy", busy, 0);
        chk("release_stop", lfsr_stop, 1);
    endtask

    initial begin
        int tgt, nr, res, mode;

        // Reset while inputs toggle
        for (int i = 0; i < 4; i++) begin
            alarm = 1'($urandom_range(0, 1));
            btn   = 4'($urandom_range(0, 15));
            tick  = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        chk_idle("reset");
        alarm = 1'b0;
        btn   = 4'd0;
        tick  = 1'b0;
        rst_n = 1'b1;
        step();

        // Win path
        start_game();
        for (int i = 0; i < ROUNDS; i++) begin
            spin(-1, tgt, nr);
            wait_phase(tgt, 5, 4'd0, res);
            chk("win_res", res, (i == ROUNDS - 1) ? 1 : 0);
        end
        finish_game();

        // Wrong presses with round_cnt=2 and target=2, then timeouts
        start_game();
        spin(1, tgt, nr); wait_phase(tgt, 5, 4'd0, res);
        spin(3, tgt, nr); wait_phase(tgt, 5, 4'd0, res);
        spin(2, tgt, nr); wait_phase(tgt, 1, 4'b0001, res);
        spin(3, tgt, nr); wait_phase(tgt, 5, 4'd0, res);
        spin(1, tgt, nr); wait_phase(tgt, 5, 4'd0, res);
        spin(2, tgt, nr); wait_phase(tgt, 1, 4'b0101, res);
        spin(1, tgt, nr); wait_phase(tgt, 2, 4'd0, res);
        spin(3, tgt, nr); wait_phase(tgt, 3, 4'd0, res);
        chk("terminal_tick_cnt", round_cnt, 1);
        alarm = 1'b0;
        step();
        chk_idle("abort_spin");

        // Repeat avoidance
        start_game();
        spin(2, tgt, nr);
        chk("first_retries", nr, 0);
        wait_phase(tgt, 5, 4'd0, res);
        spin(2, tgt, nr);
        chk("retries", nr, MAX_RETRY);
        chk("retry_target", tgt, 2);
        alarm = 1'b0;
        step();

        // Abort at round_cnt=3, then restart from round 0
        start_game();
        for (int i = 0; i < 3; i++) begin
            spin(-1, tgt, nr);
            wait_phase(tgt, 5, 4'd0, res);
        end
        chk("pre_abort_cnt", round_cnt, 3);
        spin(-1, tgt, nr);
        wait_phase(tgt, 4, 4'd0, res);
        chk("abort_res", res, 2);
        start_game();
        spin(-1, tgt, nr);
        wait_phase(tgt, 5, 4'd0, res);
        chk("restart_cnt", round_cnt, 1);

        // Mid-game reset
        step();
        rst_n = 1'b0;
        step();
        chk_idle("midreset");
        rst_n = 1'b1;
        alarm = 1'b0;
        step();

        // Random games
        for (int g = 0; g < 8; g++) begin
            start_game();
            res = 0;
            for (int r = 0; r < 60 && res == 0; r++) begin
                spin(-1, tgt, nr);
                mode = ($urandom_range(0, 19) == 0) ? 4 : 0;
                wait_phase(tgt, mode, 4'd0, res);
            end
            if (res == 1) begin
                finish_game();
            end else begin
                alarm = 1'b0;
                step();
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
